// File: rtl/cordic_vectoring_atan2.sv
// Vectoring-mode CORDIC: returns atan2(y,x) and K-scaled magnitude of a Q2.20 vector.
// Quadrant fold on accept, then ITERS micro-rotations, UNROLL per clock.
module cordic_vectoring_atan2 #(
    parameter int ITERS  = 16,
    parameter int UNROLL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic signed [21:0] x_in,
    input  logic signed [21:0] y_in,
    output logic signed [22:0] angle_out,
    output logic signed [21:0] mag_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    localparam int STEPS = ITERS / UNROLL;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);
    localparam logic signed [22:0] HALF_PI = 23'sd1647099;

    state_t            state, state_next;
    logic [CW-1:0]     iter_cnt;
    logic signed [22:0] x_reg, y_reg, z_reg;
    logic              zero_flag;

    logic signed [22:0] x_ext, y_ext;
    logic signed [22:0] step_x, step_y, step_z, step_x_old;
    int                 step_idx;

    // atan(2^-i) in Q.20, shared with the rotation-mode cosine unit
    function automatic logic signed [22:0] atan_entry(input int idx);
        case (idx)
            0:       atan_entry = 23'sh0C90FD;
            1:       atan_entry = 23'sh076B19;
            2:       atan_entry = 23'sh03EB6E;
            3:       atan_entry = 23'sh01FD5B;
            4:       atan_entry = 23'sh00FFAA;
            5:       atan_entry = 23'sh007FF5;
            6:       atan_entry = 23'sh003FFE;
            7:       atan_entry = 23'sh001FFF;
            8:       atan_entry = 23'sh000FFF;
            9:       atan_entry = 23'sh0007FF;
            10:      atan_entry = 23'sh0003FF;
            11:      atan_entry = 23'sh0001FF;
            12:      atan_entry = 23'sh0000FF;
            13:      atan_entry = 23'sh00007F;
            14:      atan_entry = 23'sh00003F;
            15:      atan_entry = 23'sh00001F;
            default: atan_entry = 23'sh000000;
        endcase
    endfunction

    assign x_ext = {x_in[21], x_in};
    assign y_ext = {y_in[21], y_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clk_en) state_next = ITER;
            ITER:    if (iter_cnt == LAST_CNT) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Each micro-rotation drives y toward zero using the pre-step x and y
    always_comb begin
        step_x     = x_reg;
        step_y     = y_reg;
        step_z     = z_reg;
        step_x_old = '0;
        step_idx   = 0;
        for (int k = 0; k < UNROLL; k++) begin
            step_idx   = int'(iter_cnt) * UNROLL + k;
            step_x_old = step_x;
            if (!step_y[22]) begin
                step_x = step_x + (step_y >>> step_idx);
                step_y = step_y - (step_x_old >>> step_idx);
                step_z = step_z + atan_entry(step_idx);
            end else begin
                step_x = step_x - (step_y >>> step_idx);
                step_y = step_y + (step_x_old >>> step_idx);
                step_z = step_z - atan_entry(step_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            iter_cnt  <= '0;
            zero_flag <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (clk_en) begin
                        iter_cnt  <= '0;
                        zero_flag <= (x_in == 22'sd0) && (y_in == 22'sd0);
                        // Fold left half-plane into the right so the rotations converge
                        if (x_in[21]) begin
                            if (!y_in[21]) begin
                                x_reg <= y_ext;
                                y_reg <= -x_ext;
                                z_reg <= HALF_PI;
                            end else begin
                                x_reg <= -y_ext;
                                y_reg <= x_ext;
                                z_reg <= -HALF_PI;
                            end
                        end else begin
                            x_reg <= x_ext;
                            y_reg <= y_ext;
                            z_reg <= '0;
                        end
                    end
                end
                ITER: begin
                    x_reg    <= step_x;
                    y_reg    <= step_y;
                    z_reg    <= step_z;
                    iter_cnt <= iter_cnt + 1'b1;
                end
                FIN: begin
                    if (zero_flag) begin
                        angle_out <= '0;
                        mag_out   <= '0;
                    end else begin
                        angle_out <= z_reg;
                        mag_out   <= x_reg[21:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_atan2.sv
// Directed bench for cordic_vectoring_atan2: quadrant cases, zero vector,
// ignored/held start strobes and mid-operation reset.
module tb_cordic_vectoring_atan2;

    logic               clk;
    logic               reset;
    logic               clk_en;
    logic signed [21:0] x_in;
    logic signed [21:0] y_in;
    logic signed [22:0] angle_out;
    logic signed [21:0] mag_out;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    localparam int HALF = 524288;
    localparam int QTR  = 262144;

    cordic_vectoring_atan2 dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Start one transaction and count edges until done; -1 if it never comes
    task automatic run_one(input int xv, input int yv, output int lat);
        x_in   = 22'(xv);
        y_in   = 22'(yv);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        clk_en = 1'b0;
        x_in   = '0;
        y_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || angle_out !== 23'sd0 || mag_out !== 22'sd0) begin
            bad++;
            $display("[TB] FAIL reset_state: busy=%0b done=%0b angle=%0d mag=%0d want all 0",
                     busy, done, angle_out, mag_out);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vector(input string name, input int xv, input int yv,
                               input int exp_ang, input int exp_mag);
        int lat;
        run_one(xv, yv, lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("[TB] FAIL %s_latency: got=%0d want=5", name, lat);
        end
        total++;
        if (iabs(int'(angle_out) - exp_ang) > 48) begin
            bad++;
            $display("[TB] FAIL %s_angle: got=%0d want=%0d+/-48", name, angle_out, exp_ang);
        end
        total++;
        if (iabs(int'(mag_out) - exp_mag) > 64) begin
            bad++;
            $display("[TB] FAIL %s_mag: got=%0d want=%0d+/-64", name, mag_out, exp_mag);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_busy_at_done: got=%0b want=0", name, busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_done_width: got=%0b want=0", name, done);
        end
    endtask

    task automatic test_zero;
        int lat;
        run_one(0, 0, lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("[TB] FAIL zero_latency: got=%0d want=5", lat);
        end
        total++;
        if (angle_out !== 23'sd0 || mag_out !== 22'sd0) begin
            bad++;
            $display("[TB] FAIL zero_result: angle=%0d mag=%0d want 0 0", angle_out, mag_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignored_start;
        int lat;
        int extra;
        x_in   = 22'(HALF);
        y_in   = 22'(0);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ignore_busy: got=%0b want=1", busy);
        end
        x_in   = 22'(0);
        y_in   = 22'(-HALF);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        lat = -1;
        for (int n = 3; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        total++;
        if (lat !== 5) begin
            bad++;
            $display("[TB] FAIL ignore_latency: got=%0d want=5", lat);
        end
        total++;
        if (iabs(int'(angle_out)) > 48) begin
            bad++;
            $display("[TB] FAIL ignore_angle: got=%0d want=0+/-48", angle_out);
        end
        extra = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_not_queued: got=%0d active cycles want=0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first  = -1;
        second = -1;
        x_in   = 22'(HALF);
        y_in   = 22'(HALF);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first < 0) begin
                    first = n;
                end else begin
                    second = n;
                    clk_en = 1'b0;
                    break;
                end
            end
        end
        clk_en = 1'b0;
        total++;
        if (first !== 5) begin
            bad++;
            $display("[TB] FAIL b2b_first: got=%0d want=5", first);
        end
        total++;
        if (second !== 11) begin
            bad++;
            $display("[TB] FAIL b2b_second: got=%0d want=11", second);
        end
        total++;
        if (iabs(int'(angle_out) - 823550) > 48) begin
            bad++;
            $display("[TB] FAIL b2b_angle: got=%0d want=823550+/-48", angle_out);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_idle_after: busy=%0b want=0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        x_in   = 22'(HALF);
        y_in   = 22'(-QTR);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || angle_out !== 23'sd0 || mag_out !== 22'sd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_clear: busy=%0b done=%0b angle=%0d mag=%0d want all 0",
                     busy, done, angle_out, mag_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL reset_mid_no_done: got=%0d active cycles want=0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_vector("pos_x",   HALF,  0,     0,        863375);
        test_vector("diag",    HALF,  HALF,  823550,   1220992);
        test_vector("neg_x",   -HALF, 0,     3294199,  863375);
        test_vector("neg_y",   0,     -HALF, -1647099, 863375);
        test_vector("q3",      -HALF, -HALF, -2470649, 1220992);
        test_vector("q4",      HALF,  -QTR,  -486170,  965283);
        test_zero;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_vector("after_rst", HALF, HALF, 823550, 1220992);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
